// File: rtl/bram_rport_arbiter.sv
// Round-robin arbiter sharing one BRAM read port among NUM_REQ requesters; write port passes through.
// Optional write-to-read forwarding is enabled by defining BRAM_RPORT_ARB_WR_FWD_EN.
module bram_rport_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int OUTER_WIDTH = 32,
  parameter int INNER_WIDTH = 32,
  localparam int IDX_W      = $clog2(OUTER_WIDTH),
  localparam int BE_W       = INNER_WIDTH / 8,
  localparam int PTR_W      = $clog2(NUM_REQ)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*IDX_W-1:0]   req_index,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         resp_valid,
  output logic [INNER_WIDTH-1:0]     resp_rdata,
  input  logic [BE_W-1:0]            wr_wen_byte,
  input  logic [IDX_W-1:0]           wr_index,
  input  logic [INNER_WIDTH-1:0]     wr_wdata,
  output logic                       bram_ren,
  output logic [IDX_W-1:0]           bram_rindex,
  input  logic [INNER_WIDTH-1:0]     bram_rdata,
  output logic [BE_W-1:0]            bram_wen_byte,
  output logic [IDX_W-1:0]           bram_windex,
  output logic [INNER_WIDTH-1:0]     bram_wdata
);

  logic [PTR_W-1:0]     r_rr_ptr;
  logic [NUM_REQ-1:0]   r_gnt_q;

  logic [2*NUM_REQ-1:0] w_rot;
  logic [PTR_W-1:0]     w_off;
  logic [PTR_W:0]       w_sum;
  logic [PTR_W-1:0]     w_win;
  logic [PTR_W-1:0]     w_ptr_next;
  logic                 w_any;
  logic [NUM_REQ-1:0]   w_gnt;
  logic [IDX_W-1:0]     w_rindex;

  // Rotate the request vector so the search always starts at bit 0, then un-rotate the offset.
  always_comb begin
    w_rot = {req_valid, req_valid} >> r_rr_ptr;
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = PTR_W'(k);
      end
    end
    w_any = |req_valid;
    w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
    if (w_sum >= (PTR_W + 1)'(NUM_REQ)) begin
      w_win = PTR_W'(w_sum - (PTR_W + 1)'(NUM_REQ));
    end else begin
      w_win = w_sum[PTR_W-1:0];
    end
    w_gnt = w_any ? (NUM_REQ'(1) << w_win) : '0;
    w_ptr_next = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + PTR_W'(1);
  end

  always_comb begin
    w_rindex = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_gnt[k]) begin
        w_rindex = req_index[k*IDX_W +: IDX_W];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rr_ptr <= '0;
      r_gnt_q  <= '0;
    end else begin
      r_gnt_q <= w_gnt;
      if (w_any) begin
        r_rr_ptr <= w_ptr_next;
      end
    end
  end

  assign req_ready     = w_gnt;
  assign bram_ren      = w_any;
  assign bram_rindex   = w_rindex;
  assign resp_valid    = r_gnt_q;
  assign bram_wen_byte = wr_wen_byte;
  assign bram_windex   = wr_index;
  assign bram_wdata    = wr_wdata;

`ifdef BRAM_RPORT_ARB_WR_FWD_EN
  logic                   r_fwd_hit;
  logic [BE_W-1:0]        r_fwd_be;
  logic [INNER_WIDTH-1:0] r_fwd_data;

  // The BRAM is read-first, so a coincident write is merged in on the response cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_fwd_hit  <= 1'b0;
      r_fwd_be   <= '0;
      r_fwd_data <= '0;
    end else begin
      r_fwd_hit  <= w_any & (|wr_wen_byte) & (wr_index == w_rindex);
      r_fwd_be   <= wr_wen_byte;
      r_fwd_data <= wr_wdata;
    end
  end

  generate
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_fwd_byte
      assign resp_rdata[gi*8 +: 8] = (r_fwd_hit & r_fwd_be[gi]) ? r_fwd_data[gi*8 +: 8]
                                                                 : bram_rdata[gi*8 +: 8];
    end
  endgenerate
`else
  assign resp_rdata = bram_rdata;
`endif

endmodule

// File: tb/tb_bram_rport_arbiter.sv
// Scoreboard bench for bram_rport_arbiter with a read-first BRAM model and a reference memory.
module tb_bram_rport_arbiter;
  localparam int N  = 4;
  localparam int IW = 5;
  localparam int DW = 32;
  localparam int BW = 4;

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*IW-1:0] req_index = '0;
  logic [N-1:0]    req_ready, resp_valid;
  logic [DW-1:0]   resp_rdata;
  logic [BW-1:0]   wr_wen_byte = '0;
  logic [IW-1:0]   wr_index = '0;
  logic [DW-1:0]   wr_wdata = '0;
  logic            bram_ren;
  logic [IW-1:0]   bram_rindex, bram_windex;
  logic [DW-1:0]   bram_rdata;
  logic [BW-1:0]   bram_wen_byte;
  logic [DW-1:0]   bram_wdata;

  bram_rport_arbiter #(.NUM_REQ(N), .OUTER_WIDTH(32), .INNER_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_index(req_index), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .wr_wen_byte(wr_wen_byte), .wr_index(wr_index), .wr_wdata(wr_wdata),
    .bram_ren(bram_ren), .bram_rindex(bram_rindex), .bram_rdata(bram_rdata),
    .bram_wen_byte(bram_wen_byte), .bram_windex(bram_windex), .bram_wdata(bram_wdata)
  );

  always #5 CLK = ~CLK;

  // Read-first BRAM attached to the arbiter's BRAM side.
  logic [DW-1:0] bmem [32];
  always @(posedge CLK) begin
    if (bram_ren) bram_rdata <= bmem[bram_rindex];
    for (int b = 0; b < BW; b++)
      if (bram_wen_byte[b]) bmem[bram_windex][b*8 +: 8] <= bram_wdata[b*8 +: 8];
  end

  typedef struct {
    logic [N-1:0]  who;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t sbq[$];

  logic [DW-1:0] ref_mem [32];
  logic [N-1:0]  rq_v;
  logic [IW-1:0] rq_i [N];
  int            rr;
  int            hold_mode;
  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: consumes expected responses whenever the DUT presents one.
  always @(negedge CLK) begin
    exp_t e;
    if (resp_valid != '0) begin
      if (sbq.size() == 0) begin
        chk("resp_unexpected", 32'(resp_valid), 32'h0);
      end else begin
        e = sbq.pop_front();
        chk("resp_valid", 32'(resp_valid), 32'(e.who));
        chk("resp_rdata", resp_rdata, e.data);
        chk("resp_latency", cyc, e.due);
      end
    end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      chk("resp_missing", 32'(resp_valid), 32'(e.who));
    end
  end

  function automatic logic [IW-1:0] rnd_idx();
    return ($urandom % 8 == 0) ? IW'($urandom_range(0, 31)) : IW'($urandom_range(0, 7));
  endfunction

  // One cycle: drive at the falling edge, check combinational paths, record the expected response.
  task automatic step(input logic [BW-1:0] wbe, input logic [IW-1:0] widx, input logic [DW-1:0] wdat);
    int            win;
    int            j;
    logic [N-1:0]  eg;
    logic [DW-1:0] ed;
    exp_t          e;
    req_valid = rq_v;
    for (int k = 0; k < N; k++) req_index[k*IW +: IW] = rq_i[k];
    wr_wen_byte = wbe;
    wr_index    = widx;
    wr_wdata    = wdat;
    #1;
    win = -1;
    for (int k = 0; k < N; k++) begin
      j = (rr + k) % N;
      if (win < 0 && rq_v[j]) win = j;
    end
    eg = (win >= 0) ? N'(1 << win) : '0;
    chk("req_ready", 32'(req_ready), 32'(eg));
    chk("bram_ren", 32'(bram_ren), 32'(win >= 0));
    chk("bram_rindex", 32'(bram_rindex), (win >= 0) ? 32'(rq_i[win]) : 32'h0);
    chk("bram_wen_byte", 32'(bram_wen_byte), 32'(wbe));
    chk("bram_windex", 32'(bram_windex), 32'(widx));
    chk("bram_wdata", bram_wdata, wdat);
    if (RST) chk("resp_valid_in_reset", 32'(resp_valid), 32'h0);
    if (win >= 0 && !RST) begin
      ed = ref_mem[rq_i[win]];
`ifdef BRAM_RPORT_ARB_WR_FWD_EN
      if (widx == rq_i[win])
        for (int b = 0; b < BW; b++)
          if (wbe[b]) ed[b*8 +: 8] = wdat[b*8 +: 8];
`endif
      e.who = eg; e.data = ed; e.due = cyc + 1;
      sbq.push_back(e);
      rr = (win + 1) % N;
    end
    for (int b = 0; b < BW; b++)
      if (wbe[b]) ref_mem[widx][b*8 +: 8] = wdat[b*8 +: 8];
    if (hold_mode == 0) begin
      for (int k = 0; k < N; k++) begin
        if (k == win && !RST) begin
          rq_v[k] = ($urandom % 4 != 0);
          rq_i[k] = rnd_idx();
        end else if (!rq_v[k] && ($urandom % 3 == 0)) begin
          rq_v[k] = 1'b1;
          rq_i[k] = rnd_idx();
        end
      end
    end
    @(negedge CLK);
  endtask

  initial begin
    logic [DW-1:0] v;
    for (int i = 0; i < 32; i++) begin
      v = $urandom;
      bmem[i] = v;
      ref_mem[i] = v;
    end
    rr = 0;
    hold_mode = 1;
    rq_v = '0;
    for (int k = 0; k < N; k++) rq_i[k] = IW'(k);
    #1 RST = 1'b1;
    @(negedge CLK);

    // Reset held with every requester valid: no responses, grant follows inputs.
    rq_v = 4'b1111;
    for (int c = 0; c < 3; c++) step('0, '0, '0);
    RST = 1'b0;

    // All four valid: rotating grants, responses one cycle later.
    for (int c = 0; c < 8; c++) step('0, '0, '0);

    // Two requesters with known contents.
    rq_v = '0;
    step(4'hF, 5'd5, 32'hA5A5A5A5);
    step(4'hF, 5'd9, 32'h5A5A5A5A);
    rq_v = 4'b1010; rq_i[1] = 5'd5; rq_i[3] = 5'd9;
    for (int c = 0; c < 6; c++) step('0, '0, '0);

    // Coincident read and partial write to the same index, then a re-read.
    rq_v = '0;
    step(4'hF, 5'd3, 32'h11223344);
    rq_v = 4'b0001; rq_i[0] = 5'd3;
    step(4'b0011, 5'd3, 32'hAABBCCDD);
    step('0, '0, '0);
    rq_v = '0;
    step('0, '0, '0);

    // Reset in the cycle after a grant drops the in-flight response and rewinds the pointer.
    rq_v = 4'b0010; rq_i[1] = 5'd7;
    step('0, '0, '0);
    @(posedge CLK);
    #1 RST = 1'b1;
    sbq.delete();
    rr = 0;
    #1 chk("resp_valid_after_reset", 32'(resp_valid), 32'h0);
    @(negedge CLK);
    rq_v = '0;
    step('0, '0, '0);
    RST = 1'b0;
    rq_v = 4'b0110; rq_i[2] = 5'd4;
    step('0, '0, '0);
    rq_v = '0;
    step('0, '0, '0);

    // Idle readers, full-mask write to the top entry.
    step(4'hF, 5'd31, 32'hC0FFEE42);
    step('0, '0, '0);

    // Random traffic.
    hold_mode = 0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom % 2 == 0) step(BW'($urandom), rnd_idx(), $urandom);
      else step('0, rnd_idx(), $urandom);
    end

    hold_mode = 1;
    rq_v = '0;
    step('0, '0, '0);
    step('0, '0, '0);
    chk("scoreboard_drained", sbq.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
